stream_link_arbiter: RTL and testbench
======================================

Name: stream_link_arbiter

Overview:
- Shares one pipelined interconnect link among n producer streams. Each stream uses the (data, valid, back-pressure) protocol, with EOS concatenated into the data.
- Each input word is captured into a small per-input buffer.
- A round-robin arbiter forwards one buffered word per cycle onto the shared link, tagged with its source index.
- The block sits upstream of a chain of registered pipeline stages. The far-end queue provides slack for the registered back-pressure latency.

Parameters:
- n, 4, number of input streams (2..16).
- width, 16, input word width, EOS in bit width-1.
- idw, 2, source-tag width; must satisfy 2^idw >= n.
- in_depth, 2, per-input buffer entries (2..8).
- eos_lock, 0, 1 = a granted source keeps the link until it forwards a word with EOS=1.

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_d  in  n*width  input data; stream k occupies bits [k*width+width-1 : k*width].
- i_v  in  n  input valid; 1 = word transferred this cycle (push semantics, no handshake).
- i_b  out  n  input back-pressure; 1 = producer must not assert i_v.
- o_d  out  idw+width  output data = {source index, word}.
- o_v  out  1  output valid, registered.
- o_b  in  1  output back-pressure from the first pipeline stage.

Behaviour:
- Reset (reset=0, async):
  - all buffer counts, read and write pointers = 0.
  - o_v=0; o_d=0.
  - rr pointer=0; lock flag=0.
  - run flag=0, so i_b=all 1.
- run sets on the first clock edge after reset deasserts. i_b stays all 1 for that first cycle.
- i_b[k] = !run | (count_k == in_depth). This is combinational from registers only, with no path from i_v or o_b.
- Push rule: if i_v[k]=1 while i_b[k]=1, the word is dropped and count is unchanged. This is a protocol violation, flagged by a bench assertion.
- Per-edge push: if i_v[k]=1 and i_b[k]=0, write i_d slice k at wptr_k; wptr_k wraps modulo in_depth.
- Eligibility: source k is eligible if count_k>0.
- Arbitration (each edge, using registered state):
  - If o_b=1, nothing pops and o_v<=0.
  - Else if the lock flag is set, only the locked source L may pop.
  - Else the winner is the first eligible source scanning rr, rr+1, ... modulo n.
  - Winner w: pop its head; o_d<={w, head}; o_v<=1; rr<=(w+1) mod n.
  - If eos_lock=1 and head EOS=0, set lock=1 and L=w. If head EOS=1, clear lock.
  - If no source is eligible (or locked L is empty): o_v<=0, o_d holds, rr and lock unchanged.
- Simultaneous push and pop on the same buffer: count unchanged, both pointers advance. A full buffer popping still shows i_b=1 that cycle; i_b deasserts the next cycle.
- Latency: a word captured at edge t appears with o_v=1 after edge t+1 at the earliest (o_b=0, source wins).
- Throughput: one word per cycle on the link; per source, at most one word per cycle.
- Ordering: order within a source is preserved. Interleaving between sources is round-robin per word; with eos_lock=1 it is per EOS-terminated message.
- eos_lock=0: the EOS bit is passed through only, no effect on arbitration.
- Reset mid-operation: buffered words are discarded, no partial output, and the lock is cleared.

Test Plan:
- Reset release, n=4, all i_v=0 -> i_b=4'b1111 on the first cycle, 4'b0000 on the next; o_v=0 throughout.
- Single source k=2 pushes 0x0011 at edge t, o_b=0 -> o_v=1, o_d={2'd2,16'h0011} after edge t+1; rr=3.
- All 4 sources keep full buffers, o_b=0 for 8 cycles -> o_d tags 0,1,2,3,0,1,2,3; o_v=1 every cycle.
- Source 1 pushes 3 words with in_depth=2 and o_b=1 -> i_b[1]=1 after 2 pushes. Releasing o_b then drains both words in order, and i_b[1] returns to 0 one cycle after the first pop.
- eos_lock=1; source 0 sends A,B,C(EOS=1) while source 1 is ready with X -> output A,B,C then X, with no interleave.
- Reset asserted with 2 words buffered and o_v=1 -> o_v=0 immediately; after release, no stale words are emitted and i_b=1 for one cycle.

Source files
------------

// File: rtl/stream_link_arbiter.sv
// Round-robin arbiter that merges n pushed streams onto one registered link.
// Each word is tagged with its source index and passes through a small per-input FIFO.
module stream_link_arbiter #(
    parameter int n        = 4,
    parameter int width    = 16,
    parameter int idw      = 2,
    parameter int in_depth = 2,
    parameter int eos_lock = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [n*width-1:0]     i_d,
    input  logic [n-1:0]           i_v,
    output logic [n-1:0]           i_b,
    output logic [idw+width-1:0]   o_d,
    output logic                   o_v,
    input  logic                   o_b
);
    localparam int cw = $clog2(in_depth + 1);
    localparam int pw = $clog2(in_depth);
    localparam logic [cw-1:0] full_count = cw'(in_depth);
    localparam logic [pw-1:0] last_ptr   = pw'(in_depth - 1);

    typedef enum logic {
        ARB_FREE,
        ARB_LOCKED
    } lock_state_t;

    logic [width-1:0] mem [n][in_depth];
    logic [cw-1:0]    count [n];
    logic [pw-1:0]    wptr [n];
    logic [pw-1:0]    rptr [n];
    logic             run;
    lock_state_t      lock_state;
    logic [idw-1:0]   lock_src;
    logic [idw-1:0]   rr;
    logic [idw-1:0]   win;
    logic [idw-1:0]   cand;
    logic             found;
    logic             grant;
    logic [n-1:0]     push;
    logic [n-1:0]     pop;
    logic [width-1:0] head;

    function automatic logic [pw-1:0] next_ptr(input logic [pw-1:0] p);
        return (p == last_ptr) ? '0 : p + 1'b1;
    endfunction

    // Back-pressure depends on registered state only, never on i_v or o_b.
    always_comb begin
        i_b  = '0;
        push = '0;
        for (int unsigned k = 0; k < n; k++) begin
            i_b[k]  = !run || (count[k] == full_count);
            push[k] = i_v[k] && !i_b[k];
        end
    end

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        if (lock_state == ARB_LOCKED) begin
            if (count[lock_src] != '0) begin
                found = 1'b1;
                win   = lock_src;
            end
        end else begin
            for (int unsigned i = 0; i < n; i++) begin
                cand = idw'((int'(rr) + int'(i)) % n);
                if (!found && count[cand] != '0) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
        end
        grant = found && !o_b;
        head  = mem[win][rptr[win]];
        pop   = '0;
        if (grant) begin
            pop[win] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned k = 0; k < n; k++) begin
            if (push[k]) begin
                mem[k][wptr[k]] <= i_d[k*width +: width];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run        <= 1'b0;
            lock_state <= ARB_FREE;
            lock_src   <= '0;
            rr         <= '0;
            o_v        <= 1'b0;
            o_d        <= '0;
            for (int unsigned k = 0; k < n; k++) begin
                count[k] <= '0;
                wptr[k]  <= '0;
                rptr[k]  <= '0;
            end
        end else begin
            run <= 1'b1;
            for (int unsigned k = 0; k < n; k++) begin
                if (push[k]) begin
                    wptr[k] <= next_ptr(wptr[k]);
                end
                if (pop[k]) begin
                    rptr[k] <= next_ptr(rptr[k]);
                end
                if (push[k] && !pop[k]) begin
                    count[k] <= count[k] + 1'b1;
                end else if (pop[k] && !push[k]) begin
                    count[k] <= count[k] - 1'b1;
                end
            end
            if (grant) begin
                o_d <= {win, head};
                o_v <= 1'b1;
                rr  <= (win == idw'(n - 1)) ? '0 : win + 1'b1;
                // A message holds the link until its EOS word has been forwarded.
                if (eos_lock != 0) begin
                    lock_state <= head[width-1] ? ARB_FREE : ARB_LOCKED;
                    lock_src   <= win;
                end
            end else begin
                o_v <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stream_link_arbiter.sv
// Bench for stream_link_arbiter: two instances (eos_lock 0 and 1) share stimulus and
// are checked each cycle against a queue-based model plus literal directed expectations.
module tb_stream_link_arbiter;
    localparam int N   = 4;
    localparam int W   = 16;
    localparam int IDW = 2;
    localparam int D   = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [N*W-1:0]   i_d;
    logic [N-1:0]     i_v;
    logic             o_b;
    logic [N-1:0]     ib0, ib1;
    logic [IDW+W-1:0] od0, od1;
    logic             ov0, ov1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    stream_link_arbiter #(.n(N), .width(W), .idw(IDW), .in_depth(D), .eos_lock(0)) u0 (
        .clock(clock), .reset(reset), .i_d(i_d), .i_v(i_v), .i_b(ib0),
        .o_d(od0), .o_v(ov0), .o_b(o_b)
    );

    stream_link_arbiter #(.n(N), .width(W), .idw(IDW), .in_depth(D), .eos_lock(1)) u1 (
        .clock(clock), .reset(reset), .i_d(i_d), .i_v(i_v), .i_b(ib1),
        .o_d(od1), .o_v(ov1), .o_b(o_b)
    );

    always #5 clock = ~clock;

    // Reference model: one queue per (instance, source).
    logic [W-1:0]     mq [2*N][$];
    int               m_rr [2];
    bit               m_lk [2];
    int               m_ls [2];
    bit               m_run [2];
    logic [IDW+W-1:0] m_od [2];
    bit               m_ov [2];

    function automatic bit mib(int u, int k);
        return !m_run[u] || (mq[u*N+k].size() == D);
    endfunction

    function automatic logic [N-1:0] mibv(int u);
        logic [N-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k] = mib(u, k);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int q = 0; q < 2*N; q++) mq[q].delete();
        for (int u = 0; u < 2; u++) begin
            m_rr[u] = 0; m_lk[u] = 1'b0; m_ls[u] = 0;
            m_run[u] = 1'b0; m_od[u] = '0; m_ov[u] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] pm [2];
        int           w;
        int           c;
        bit           found;
        logic [W-1:0] head;
        for (int u = 0; u < 2; u++)
            for (int k = 0; k < N; k++) pm[u][k] = i_v[k] && !mib(u, k);
        for (int u = 0; u < 2; u++) begin
            if (o_b) begin
                m_ov[u] = 1'b0;
            end else begin
                found = 1'b0;
                w = 0;
                if (m_lk[u]) begin
                    if (mq[u*N+m_ls[u]].size() > 0) begin found = 1'b1; w = m_ls[u]; end
                end else begin
                    for (int i = 0; i < N; i++) begin
                        c = (m_rr[u] + i) % N;
                        if (!found && mq[u*N+c].size() > 0) begin found = 1'b1; w = c; end
                    end
                end
                if (found) begin
                    head = mq[u*N+w].pop_front();
                    m_od[u] = {w[1:0], head};
                    m_ov[u] = 1'b1;
                    m_rr[u] = (w + 1) % N;
                    if (u == 1) begin
                        m_lk[u] = !head[W-1];
                        m_ls[u] = w;
                    end
                end else begin
                    m_ov[u] = 1'b0;
                end
            end
        end
        for (int u = 0; u < 2; u++)
            for (int k = 0; k < N; k++)
                if (pm[u][k]) mq[u*N+k].push_back(i_d[k*W +: W]);
        m_run[0] = 1'b1;
        m_run[1] = 1'b1;
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("o_v inst0", ov0, m_ov[0]);
            check("o_d inst0", od0, m_od[0]);
            check("i_b inst0", ib0, mibv(0));
            check("o_v inst1", ov1, m_ov[1]);
            check("o_d inst1", od1, m_od[1]);
            check("i_b inst1", ib1, mibv(1));
        end
    end

    always @(posedge clock) begin
        if (chk_en) check("push while back-pressured", i_v & (ib0 | ib1), 0);
    end

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        #1;
    endtask

    task automatic setw(input int k, input logic [W-1:0] v);
        i_d[k*W +: W] = v;
    endtask

    initial begin
        i_v = '0; i_d = '0; o_b = 1'b0;
        model_reset();
        #1 reset = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1 reset = 1'b1;
        check("release i_b inst0", ib0, 4'hF);
        check("release i_b inst1", ib1, 4'hF);
        check("release o_v", {ov1, ov0}, 2'b00);
        step();
        check("run i_b inst0", ib0, 4'h0);
        check("run i_b inst1", ib1, 4'h0);

        // single word from source 2
        i_v = 4'b0100; setw(2, 16'h0011);
        step();
        i_v = '0;
        check("single latency o_v", ov0, 0);
        step();
        check("single o_v", {ov1, ov0}, 2'b11);
        check("single o_d inst0", od0, {2'd2, 16'h0011});
        check("single o_d inst1", od1, {2'd2, 16'h0011});

        // rr=3 in inst0; inst1 is locked on source 2 (EOS was 0)
        i_v = 4'b1101; setw(0, 16'h8100); setw(2, 16'h8102); setw(3, 16'h8103);
        step();
        i_v = '0;
        step();
        check("rr1 inst0", od0, {2'd3, 16'h8103});
        check("rr1 inst1", od1, {2'd2, 16'h8102});
        step();
        check("rr2 inst0", od0, {2'd0, 16'h8100});
        check("rr2 inst1", od1, {2'd3, 16'h8103});
        step();
        check("rr3 inst0", od0, {2'd2, 16'h8102});
        check("rr3 inst1", od1, {2'd0, 16'h8100});

        // all sources full, round-robin rotation
        o_b = 1'b1;
        i_v = 4'hF;
        for (int k = 0; k < N; k++) setw(k, 16'h8000 | 16'(k * 16));
        step();
        for (int k = 0; k < N; k++) setw(k, 16'h8001 | 16'(k * 16));
        step();
        o_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < N; k++) begin
                i_v[k] = !mib(0, k) && !mib(1, k);
                setw(k, 16'h8000 | 16'(k * 16 + i + 2));
            end
            step();
            check("rotate o_v", {ov1, ov0}, 2'b11);
            check("rotate tag inst0", od0[W+IDW-1:W], (3 + i) % 4);
            check("rotate tag inst1", od1[W+IDW-1:W], (1 + i) % 4);
        end
        i_v = '0;
        repeat (10) step();

        // fill source 1 under back-pressure, then drain
        o_b = 1'b1;
        i_v = 4'b0010; setw(1, 16'h0041);
        step();
        setw(1, 16'h8042);
        step();
        i_v = '0;
        check("full i_b[1] inst0", ib0[1], 1);
        check("full i_b[1] inst1", ib1[1], 1);
        o_b = 1'b0;
        step();
        check("drain1 o_d", od0, {2'd1, 16'h0041});
        check("drain1 i_b[1]", {ib1[1], ib0[1]}, 2'b00);
        step();
        check("drain2 o_d", od1, {2'd1, 16'h8042});
        step();
        check("drain idle o_v", {ov1, ov0}, 2'b00);

        // EOS-terminated message from source 0 against a waiting word on source 1
        o_b = 1'b1;
        i_v = 4'b0011; setw(0, 16'h00A1); setw(1, 16'h80F1);
        step();
        i_v = 4'b0001; setw(0, 16'h00B2);
        step();
        i_v = '0; o_b = 1'b0;
        step();
        check("msg A inst1", od1, {2'd0, 16'h00A1});
        check("msg A inst0", od0, {2'd0, 16'h00A1});
        i_v = 4'b0001; setw(0, 16'h80C3);
        step();
        i_v = '0;
        check("msg B inst1", od1, {2'd0, 16'h00B2});
        check("msg X inst0", od0, {2'd1, 16'h80F1});
        step();
        check("msg C inst1", od1, {2'd0, 16'h80C3});
        step();
        check("msg X inst1", od1, {2'd1, 16'h80F1});
        check("msg C inst0", od0, {2'd0, 16'h80C3});

        // reset while words are buffered and the link is active
        o_b = 1'b1;
        i_v = 4'b0100; setw(2, 16'h8201);
        step();
        setw(2, 16'h8202);
        step();
        o_b = 1'b0;
        i_v = 4'b1000; setw(3, 16'h8301);
        step();
        i_v = '0;
        check("pre-reset o_v", {ov1, ov0}, 2'b11);
        reset = 1'b0;
        model_reset();
        #1;
        check("async reset o_v", {ov1, ov0}, 2'b00);
        check("async reset o_d", od0, 0);
        check("async reset i_b", ib1, 4'hF);
        @(posedge clock);
        @(negedge clock);
        #1 reset = 1'b1;
        check("re-release i_b", ib0, 4'hF);
        step();
        check("re-run i_b", {ib1, ib0}, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            check("no stale o_v", {ov1, ov0}, 2'b00);
        end

        // randomized traffic
        for (int cyc = 0; cyc < 600; cyc++) begin
            o_b = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < N; k++) begin
                i_v[k] = 1'b0;
                if (!mib(0, k) && !mib(1, k) && $urandom_range(0, 1) == 1) begin
                    i_v[k] = 1'b1;
                    setw(k, {($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, 15'($urandom)});
                end
            end
            step();
        end
        i_v = '0; o_b = 1'b0;
        repeat (12) step();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
